// File: rtl/backprop_pkg.sv
// Shared definitions for the backprop datapath blocks (delta_backprop, weight_updater).
package backprop_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE
  } state_t;

  // Ceiling log2; returns 0 for value <= 1 so single-neuron builds still elaborate.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/sigmoid_derivative.sv
// Combinational sigmoid derivative a*(1-a) in fixed point, with a clamped to 1.0.
module sigmoid_derivative #(
  parameter int ACTIVATION_WIDTH = 9,
  parameter int FRACTION_WIDTH   = 8
) (
  input  logic [ACTIVATION_WIDTH-1:0] a,
  output logic [FRACTION_WIDTH:0]     dsig
);

  localparam int F   = FRACTION_WIDTH;
  localparam int ONE = 1 << F;

  logic [F:0]     a_clamp;
  logic [2*F+1:0] prod;

  // Activations at or beyond 1.0 clamp to 1.0, which makes (1 - a) and the derivative zero.
  always_comb begin
    if (32'(a) >= ONE) begin
      a_clamp = (F+1)'(ONE);
    end else begin
      a_clamp = (F+1)'(a);
    end
    prod = (2*F+2)'(a_clamp) * (2*F+2)'((F+1)'(ONE) - a_clamp);
    dsig = (F+1)'(prod >> F);
  end

endmodule

// File: rtl/delta_backprop.sv
// Back-propagates upper-layer deltas through the weight matrix, one upper neuron per
// cycle with N parallel MACs, then scales by the sigmoid derivative and saturates.
module delta_backprop
  import backprop_pkg::*;
#(
  parameter int NEURON_NUM        = 5,
  parameter int ACTIVATION_WIDTH  = 9,
  parameter int DELTA_CELL_WIDTH  = 10,
  parameter int WEIGHT_CELL_WIDTH = 16,
  parameter int FRACTION_WIDTH    = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]              a,
  input  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]              delta,
  input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]  w,
  output logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]              result,
  output logic                                                valid,
  output logic                                                error
);

  localparam int N      = NEURON_NUM;
  localparam int AW     = ACTIVATION_WIDTH;
  localparam int D      = DELTA_CELL_WIDTH;
  localparam int WW     = WEIGHT_CELL_WIDTH;
  localparam int F      = FRACTION_WIDTH;
  localparam int ACC_W  = WW + D + clog2(N);
  localparam int CNT_W  = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int PROD_W = ACC_W + F + 2;

  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'((2 ** (D - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-(2 ** (D - 1)));

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc      [N];
  logic signed [ACC_W-1:0]   next_acc [N];
  logic [F:0]                dsig     [N];
  logic [N*D-1:0]            result_sat;
  logic [N-1:0]              sat_flags;

  for (genvar j = 0; j < N; j++) begin : g_dsig
    sigmoid_derivative #(
      .ACTIVATION_WIDTH (AW),
      .FRACTION_WIDTH   (F)
    ) u_dsig (
      .a    (a[j*AW +: AW]),
      .dsig (dsig[j])
    );
  end

  // Row cnt of the weight matrix times delta[cnt] feeds all columns at once; the
  // scale path works on the current accumulators and is only captured in SCALE.
  always_comb begin
    logic signed [D-1:0]       delta_sel;
    logic signed [WW-1:0]      w_sel;
    logic signed [WW+D-1:0]    mac;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [PROD_W-1:0]  scaled;
    logic signed [PROD_W-1:0]  q;
    result_sat = '0;
    sat_flags  = '0;
    delta_sel  = delta[int'(cnt)*D +: D];
    for (int j = 0; j < N; j++) begin
      w_sel       = w[(int'(cnt)*N + j)*WW +: WW];
      mac         = w_sel * delta_sel;
      next_acc[j] = acc[j] + ACC_W'(mac);
      shifted     = acc[j] >>> F;
      scaled      = PROD_W'(shifted) * PROD_W'($signed({1'b0, dsig[j]}));
      q           = scaled >>> F;
      if (q > SAT_HI) begin
        result_sat[j*D +: D] = D'(SAT_HI);
        sat_flags[j]         = 1'b1;
      end else if (q < SAT_LO) begin
        result_sat[j*D +: D] = D'(SAT_LO);
        sat_flags[j]         = 1'b1;
      end else begin
        result_sat[j*D +: D] = D'(q);
      end
    end
  end

  // A start arriving while valid is still showing belongs to the finished result and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      valid  <= 1'b0;
      error  <= 1'b0;
      for (int j = 0; j < N; j++) acc[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start && !valid) begin
            state  <= ACCUM;
            cnt    <= '0;
            result <= '0;
            error  <= 1'b0;
            for (int j = 0; j < N; j++) acc[j] <= '0;
          end
        end
        ACCUM: begin
          for (int j = 0; j < N; j++) acc[j] <= next_acc[j];
          if (cnt == CNT_W'(N - 1)) begin
            cnt   <= '0;
            state <= SCALE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCALE: begin
          result <= result_sat;
          error  <= |sat_flags;
          valid  <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delta_backprop.sv
// Self-checking bench for delta_backprop: an arithmetic reference model compared every cycle
// plus literal expectations for the characteristic vectors.
module tb_delta_backprop;

  localparam int N  = 5;
  localparam int AW = 9;
  localparam int D  = 10;
  localparam int WW = 16;
  localparam int F  = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [N*AW-1:0]     a_in = '0;
  logic [N*D-1:0]      delta_in = '0;
  logic [N*N*WW-1:0]   w_in = '0;
  logic [N*D-1:0]      result;
  logic                valid;
  logic                error;

  int checks_total  = 0;
  int checks_passed = 0;
  int edge_cnt      = 0;
  int start_edge    = 0;
  bit compare_en    = 1'b0;

  int             model_busy   = 0;
  logic           model_valid  = 1'b0;
  logic [N*D-1:0] model_result = '0;
  logic           model_error  = 1'b0;

  always #5 clk = ~clk;

  delta_backprop #(
    .NEURON_NUM        (N),
    .ACTIVATION_WIDTH  (AW),
    .DELTA_CELL_WIDTH  (D),
    .WEIGHT_CELL_WIDTH (WW),
    .FRACTION_WIDTH    (F)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a_in),
    .delta  (delta_in),
    .w      (w_in),
    .result (result),
    .valid  (valid),
    .error  (error)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference arithmetic straight from the definition, in 64-bit integers.
  function automatic void model_compute(output logic [N*D-1:0] res, output logic err);
    longint sum, sh, q;
    longint ac, ds;
    longint hi, lo;
    hi  = (64'sd1 <<< (D - 1)) - 1;
    lo  = -(64'sd1 <<< (D - 1));
    res = '0;
    err = 1'b0;
    for (int j = 0; j < N; j++) begin
      sum = 0;
      for (int i = 0; i < N; i++)
        sum += longint'($signed(w_in[(i*N + j)*WW +: WW])) * longint'($signed(delta_in[i*D +: D]));
      sh = sum >>> F;
      ac = longint'(a_in[j*AW +: AW]);
      if (ac > (64'sd1 <<< F)) ac = 64'sd1 <<< F;
      ds = (ac * ((64'sd1 <<< F) - ac)) >>> F;
      q  = (sh * ds) >>> F;
      if (q > hi) begin q = hi; err = 1'b1; end
      if (q < lo) begin q = lo; err = 1'b1; end
      res[j*D +: D] = q[D-1:0];
    end
  endfunction

  // Transaction-level timing model: an accepted start yields valid N+1 edges later.
  always @(posedge clk) begin
    logic [N*D-1:0] tmp_res;
    logic           tmp_err;
    edge_cnt <= edge_cnt + 1;
    if (rst) begin
      model_busy   <= 0;
      model_valid  <= 1'b0;
      model_result <= '0;
      model_error  <= 1'b0;
    end else if (model_busy > 0) begin
      model_busy  <= model_busy - 1;
      model_valid <= (model_busy == 1);
      if (model_busy == 1) begin
        model_compute(tmp_res, tmp_err);
        model_result <= tmp_res;
        model_error  <= tmp_err;
      end
    end else begin
      model_valid <= 1'b0;
      if (start && !model_valid) begin
        model_busy   <= N + 1;
        model_result <= '0;
        model_error  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("cycle_valid", 64'(valid), 64'(model_valid));
      checkOutput("cycle_result", 64'(result), 64'(model_result));
      checkOutput("cycle_error", 64'(error), 64'(model_error));
    end
  end

  task automatic setUniform(input int av, input int dv, input int wv);
    for (int j = 0; j < N; j++) a_in[j*AW +: AW] = AW'(av);
    for (int i = 0; i < N; i++) delta_in[i*D +: D] = D'(dv);
    for (int k = 0; k < N*N; k++) w_in[k*WW +: WW] = WW'(wv);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start_edge = edge_cnt;
    start = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = -1;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (valid) begin
        lat = edge_cnt - start_edge;
        break;
      end
    end
  endtask

  task automatic checkCells(input string name, input int cell_idx, input int expected);
    for (int j = 0; j < N; j++) begin
      if (cell_idx < 0 || cell_idx == j)
        checkOutput(name, 64'(longint'($signed(result[j*D +: D]))), 64'(longint'(expected)));
    end
  endtask

  task automatic countValid(input int cycles, output int hits);
    hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid) hits++;
    end
  endtask

  initial begin
    int lat;
    int hits;
    rst = 1'b1;
    @(negedge clk);
    compare_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_valid", 64'(valid), 64'd0);
    checkOutput("reset_error", 64'(error), 64'd0);
    rst = 1'b0;
    countValid(20, hits);
    checkOutput("idle_no_valid", 64'(hits), 64'd0);

    setUniform(128, 256, 256);
    applyStimulus();
    waitValid(lat);
    checkOutput("uniform_latency", 64'(lat), 64'd6);
    checkCells("uniform_cell", -1, 320);
    checkOutput("uniform_error", 64'(error), 64'd0);

    setUniform(0, 0, 0);
    w_in[(2*N + 3)*WW +: WW] = 16'd512;
    delta_in[2*D +: D]       = D'(-128);
    a_in[3*AW +: AW]         = 9'd128;
    applyStimulus();
    waitValid(lat);
    checkCells("single_link_cell3", 3, -64);
    checkCells("single_link_cell0", 0, 0);
    checkOutput("single_link_error", 64'(error), 64'd0);

    setUniform(128, 511, 32767);
    applyStimulus();
    waitValid(lat);
    checkCells("sat_pos_cell", -1, 511);
    checkOutput("sat_pos_error", 64'(error), 64'd1);

    setUniform(128, 511, -32768);
    applyStimulus();
    waitValid(lat);
    checkCells("sat_neg_cell", -1, -512);
    checkOutput("sat_neg_error", 64'(error), 64'd1);

    setUniform(0, 300, 1000);
    applyStimulus();
    waitValid(lat);
    checkCells("a_zero_cell", -1, 0);
    checkOutput("a_zero_error", 64'(error), 64'd0);

    setUniform(256, 300, 1000);
    applyStimulus();
    waitValid(lat);
    checkCells("a_one_cell", -1, 0);
    checkOutput("a_one_error", 64'(error), 64'd0);

    setUniform(511, -200, -700);
    applyStimulus();
    waitValid(lat);
    checkCells("a_over_cell", -1, 0);

    a_in     = {9'd255, 9'd200, 9'd128, 9'd60, 9'd10};
    delta_in = {10'sd7, -10'sd512, 10'sd511, -10'sd50, 10'sd100};
    for (int k = 0; k < N*N; k++) w_in[k*WW +: WW] = WW'((k * 1237) % 4000 - 2000);
    applyStimulus();
    waitValid(lat);
    checkOutput("mixed_latency", 64'(lat), 64'd6);

    setUniform(128, 256, 256);
    applyStimulus();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitValid(lat);
    checkOutput("repulse_latency", 64'(lat), 64'd6);
    checkCells("repulse_cell", 2, 320);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    countValid(12, hits);
    checkOutput("start_with_valid_ignored", 64'(hits), 64'd0);

    applyStimulus();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    countValid(12, hits);
    checkOutput("abort_no_valid", 64'(hits), 64'd0);
    checkOutput("abort_result", 64'(result), 64'd0);
    checkOutput("abort_error", 64'(error), 64'd0);

    applyStimulus();
    waitValid(lat);
    checkOutput("after_reset_latency", 64'(lat), 64'd6);
    checkCells("after_reset_cell", -1, 320);
    checkOutput("after_reset_error", 64'(error), 64'd0);

    repeat (3) @(negedge clk);
    compare_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
